// File: rtl/bcd_alu_seq_if.sv
// Handshake and operand/result bundle between the keypad operand registers,
// the BCD arithmetic unit and the display driver.
interface bcd_alu_seq_if #(
    parameter int DIGITS = 2
);
    logic                  i_start;
    logic [1:0]            i_op;
    logic [4*DIGITS-1:0]   i_a;
    logic [4*DIGITS-1:0]   i_b;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_result_lo;
    logic [4*DIGITS-1:0]   o_result_hi;
    logic                  o_neg;
    logic                  o_err;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_result_lo, o_result_hi, o_neg, o_err
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_result_lo, o_result_hi, o_neg, o_err
    );
endinterface

// File: rtl/bcd_alu_seq.sv
// Sequential packed-BCD add/sub/mult/div unit: operands go to binary, the
// op runs in binary, and the result returns to BCD by double dabble.
module bcd_alu_seq #(
    parameter int DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    bcd_alu_seq_if.slave  bus
);
    localparam int BW = $clog2(10**DIGITS);
    localparam int PW = 2 * BW;
    localparam int CW = $clog2(PW) + 1;
    localparam int NW = 4 * DIGITS;

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, CONV, DONE} stateT;

    stateT            r_state;
    stateT            w_nextState;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;

    logic [1:0]       r_op;
    logic [NW-1:0]    r_a;
    logic [NW-1:0]    r_b;
    logic [BW-1:0]    r_binA;
    logic [BW-1:0]    r_binB;
    logic             r_err;
    logic             r_negInt;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_valX;
    logic [PW-1:0]    r_valY;
    logic [2*NW-1:0]  r_bcdX;
    logic [NW-1:0]    r_bcdY;

    logic [NW-1:0]    r_resLo;
    logic [NW-1:0]    r_resHi;
    logic             r_outNeg;
    logic             r_outErr;

    logic [BW:0]      w_divTrial;
    logic             w_divGe;
    logic [BW:0]      w_divRem;
    logic [2*NW-1:0]  w_bcdXNext;
    logic [NW-1:0]    w_bcdYNext;

    function automatic logic [BW-1:0] bcdToBin(input logic [NW-1:0] v);
        int unsigned acc;
        acc = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc * 10 + 32'(v[4*i +: 4]);
        end
        return BW'(acc);
    endfunction

    function automatic logic hasNonBcd(input logic [NW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One double-dabble step: add 3 to every digit >= 5, then shift a bit in.
    function automatic logic [2*NW-1:0] ddWide(input logic [2*NW-1:0] v, input logic bitIn);
        logic [2*NW-1:0] t;
        t = v;
        for (int i = 0; i < 2 * DIGITS; i++) begin
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return (t << 1) | {{(2*NW-1){1'b0}}, bitIn};
    endfunction

    function automatic logic [NW-1:0] ddNarrow(input logic [NW-1:0] v, input logic bitIn);
        logic [NW-1:0] t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return (t << 1) | {{(NW-1){1'b0}}, bitIn};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_busy      = 1'b1;
                w_nextState = EXEC;
            end
            EXEC: begin
                w_busy = 1'b1;
                if (r_op != 2'd3 || r_cnt == CW'(BW - 1)) w_nextState = CONV;
            end
            CONV: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(PW - 1)) w_nextState = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (bus.i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = LOAD;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Restoring division keeps the quotient in the low BW bits of r_valX and
    // the partial remainder in r_valY, so CONV can shift both straight out.
    assign w_divTrial = {r_valY[BW-1:0], r_valX[BW-1]};
    assign w_divGe    = (w_divTrial >= {1'b0, r_binB});
    assign w_divRem   = w_divGe ? (w_divTrial - {1'b0, r_binB}) : w_divTrial;
    assign w_bcdXNext = ddWide(r_bcdX, r_valX[PW-1]);
    assign w_bcdYNext = ddNarrow(r_bcdY, r_valY[PW-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_binA   <= '0;
            r_binB   <= '0;
            r_err    <= 1'b0;
            r_negInt <= 1'b0;
            r_cnt    <= '0;
            r_valX   <= '0;
            r_valY   <= '0;
            r_bcdX   <= '0;
            r_bcdY   <= '0;
            r_resLo  <= '0;
            r_resHi  <= '0;
            r_outNeg <= 1'b0;
            r_outErr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.i_op;
                r_a  <= bus.i_a;
                r_b  <= bus.i_b;
            end
            case (r_state)
                LOAD: begin
                    r_binA   <= bcdToBin(r_a);
                    r_binB   <= bcdToBin(r_b);
                    r_err    <= hasNonBcd(r_a) | hasNonBcd(r_b) | (r_op == 2'd3 && r_b == '0);
                    r_negInt <= 1'b0;
                    r_cnt    <= '0;
                    r_valX   <= PW'(bcdToBin(r_a));
                    r_valY   <= '0;
                    r_bcdX   <= '0;
                    r_bcdY   <= '0;
                end
                EXEC: begin
                    r_cnt <= (w_nextState != r_state) ? '0 : r_cnt + CW'(1);
                    case (r_op)
                        2'd0: r_valX <= PW'(r_binA) + PW'(r_binB);
                        2'd1: begin
                            if (r_binA >= r_binB) begin
                                r_valX   <= PW'(r_binA - r_binB);
                                r_negInt <= 1'b0;
                            end else begin
                                r_valX   <= PW'(r_binB - r_binA);
                                r_negInt <= 1'b1;
                            end
                        end
                        2'd2: r_valX <= PW'(r_binA) * PW'(r_binB);
                        default: begin
                            r_valX <= PW'({r_valX[BW-2:0], w_divGe});
                            r_valY <= PW'(w_divRem);
                        end
                    endcase
                end
                CONV: begin
                    r_cnt  <= (w_nextState != r_state) ? '0 : r_cnt + CW'(1);
                    r_valX <= r_valX << 1;
                    r_valY <= r_valY << 1;
                    r_bcdX <= w_bcdXNext;
                    r_bcdY <= w_bcdYNext;
                    if (w_nextState == DONE) begin
                        r_outErr <= r_err;
                        if (r_err) begin
                            r_resLo  <= '0;
                            r_resHi  <= '0;
                            r_outNeg <= 1'b0;
                        end else if (r_op == 2'd3) begin
                            r_resLo  <= w_bcdXNext[NW-1:0];
                            r_resHi  <= w_bcdYNext;
                            r_outNeg <= 1'b0;
                        end else begin
                            r_resLo  <= w_bcdXNext[NW-1:0];
                            r_resHi  <= w_bcdXNext[2*NW-1:NW];
                            r_outNeg <= r_negInt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy      = w_busy;
    assign bus.o_done      = w_done;
    assign bus.o_result_lo = r_resLo;
    assign bus.o_result_hi = r_resHi;
    assign bus.o_neg       = r_outNeg;
    assign bus.o_err       = r_outErr;
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Directed bench for bcd_alu_seq (DIGITS=2): results, latency, error forcing,
// handshake corner cases and mid-operation reset.
module tb_bcd_alu_seq;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    bcd_alu_seq_if #(.DIGITS(2)) bus ();

    bcd_alu_seq #(.DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitDone(output int cycles);
        logic doneSeen;
        cycles   = 0;
        doneSeen = 1'b0;
        while (!doneSeen && cycles < 60) begin
            @(posedge clk);
            cycles++;
            #1;
            doneSeen = bus.o_done;
        end
    endtask

    // Launches one op, scrambles the inputs after the accept edge, optionally
    // pulses start at cycle pulseAt, then checks latency and results.
    task automatic applyStimulus(input string tag, input logic [1:0] opIn,
                                 input logic [7:0] aIn, input logic [7:0] bIn,
                                 input int pulseAt, input int expLat,
                                 input logic [7:0] expHi, input logic [7:0] expLo,
                                 input logic expNeg, input logic expErr);
        int   cycles;
        logic doneSeen;
        @(negedge clk);
        bus.i_op    = opIn;
        bus.i_a     = aIn;
        bus.i_b     = bIn;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_op    = ~opIn;
        bus.i_a     = 8'hFF;
        bus.i_b     = 8'hFF;
        checkOutput({tag, " busy"}, 32'(bus.o_busy), 32'd1);
        cycles   = 0;
        doneSeen = 1'b0;
        while (!doneSeen && cycles < 60) begin
            @(negedge clk);
            bus.i_start = (cycles + 1 == pulseAt);
            @(posedge clk);
            cycles++;
            #1;
            doneSeen = bus.o_done;
        end
        bus.i_start = 1'b0;
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, " hi"}, 32'(bus.o_result_hi), 32'(expHi));
        checkOutput({tag, " lo"}, 32'(bus.o_result_lo), 32'(expLo));
        checkOutput({tag, " neg"}, 32'(bus.o_neg), 32'(expNeg));
        checkOutput({tag, " err"}, 32'(bus.o_err), 32'(expErr));
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse width"}, 32'(bus.o_done), 32'd0);
    endtask

    initial begin
        int cycles;
        int donePulses;
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_op    = 2'd0;
        bus.i_a     = 8'h00;
        bus.i_b     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.o_busy), 32'd0);
        checkOutput("reset done", 32'(bus.o_done), 32'd0);
        checkOutput("reset lo", 32'(bus.o_result_lo), 32'd0);
        checkOutput("reset hi", 32'(bus.o_result_hi), 32'd0);
        checkOutput("reset neg", 32'(bus.o_neg), 32'd0);
        checkOutput("reset err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("sum 57+68", 2'd0, 8'h57, 8'h68, 0, 16, 8'h01, 8'h25, 1'b0, 1'b0);
        applyStimulus("sum 99+99", 2'd0, 8'h99, 8'h99, 0, 16, 8'h01, 8'h98, 1'b0, 1'b0);
        applyStimulus("sub 23-58", 2'd1, 8'h23, 8'h58, 0, 16, 8'h00, 8'h35, 1'b1, 1'b0);
        applyStimulus("sub 42-42", 2'd1, 8'h42, 8'h42, 0, 16, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus("mult 99*99", 2'd2, 8'h99, 8'h99, 0, 16, 8'h98, 8'h01, 1'b0, 1'b0);
        applyStimulus("mult 00*75", 2'd2, 8'h00, 8'h75, 0, 16, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus("div 97/07", 2'd3, 8'h97, 8'h07, 0, 22, 8'h06, 8'h13, 1'b0, 1'b0);
        applyStimulus("div 05/09", 2'd3, 8'h05, 8'h09, 0, 22, 8'h05, 8'h00, 1'b0, 1'b0);
        applyStimulus("div by zero", 2'd3, 8'h97, 8'h00, 0, 22, 8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus("sum nonbcd a", 2'd0, 8'h1A, 8'h05, 0, 16, 8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus("sub nonbcd b", 2'd1, 8'h23, 8'h5C, 0, 16, 8'h00, 8'h00, 1'b0, 1'b1);

        // A start pulse mid-mult must not be queued.
        applyStimulus("mult 12*34 w/ pulse", 2'd2, 8'h12, 8'h34, 5, 16, 8'h04, 8'h08, 1'b0, 1'b0);
        donePulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done || bus.o_busy) donePulses++;
        end
        checkOutput("ignored start activity", 32'(donePulses), 32'd0);

        // start held through DONE: second op follows with no idle cycle.
        @(negedge clk);
        bus.i_op    = 2'd0;
        bus.i_a     = 8'h12;
        bus.i_b     = 8'h34;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_op = 2'd2;
        bus.i_a  = 8'h25;
        bus.i_b  = 8'h04;
        waitDone(cycles);
        checkOutput("b2b first latency", 32'(cycles), 32'd16);
        checkOutput("b2b first lo", 32'(bus.o_result_lo), 32'h46);
        checkOutput("b2b first hi", 32'(bus.o_result_hi), 32'h00);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_a     = 8'hFF;
        bus.i_b     = 8'hFF;
        checkOutput("b2b busy no gap", 32'(bus.o_busy), 32'd1);
        checkOutput("b2b done dropped", 32'(bus.o_done), 32'd0);
        waitDone(cycles);
        checkOutput("b2b second latency", 32'(cycles), 32'd16);
        checkOutput("b2b second hi", 32'(bus.o_result_hi), 32'h01);
        checkOutput("b2b second lo", 32'(bus.o_result_lo), 32'h00);

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.i_op    = 2'd3;
        bus.i_a     = 8'h97;
        bus.i_b     = 8'h07;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("pre-reset busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid-op reset busy", 32'(bus.o_busy), 32'd0);
        checkOutput("mid-op reset done", 32'(bus.o_done), 32'd0);
        checkOutput("mid-op reset hi", 32'(bus.o_result_hi), 32'd0);
        checkOutput("mid-op reset lo", 32'(bus.o_result_lo), 32'd0);
        checkOutput("mid-op reset err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        donePulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) donePulses++;
        end
        checkOutput("no done after reset", 32'(donePulses), 32'd0);
        applyStimulus("sum 45+38 after reset", 2'd0, 8'h45, 8'h38, 0, 16, 8'h00, 8'h83, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/bcd_alu_seq.md
# bcd_alu_seq

Sequential, parametrised BCD arithmetic unit: add, subtract, multiply and divide on two DIGITS-digit packed-BCD operands. It produces a double-width BCD result with status flags. Operations are launched with a start/done handshake and run with fixed, op-dependent latency through a binary datapath and a double-dabble back-conversion. The block sits between the keypad/operand registers and the 7-segment display driver, and replaces the single-digit combinational ALU.

## Interface
- DIGITS, 2, BCD digits per operand (≥1)
- BW (localparam), bits to hold 10^DIGITS−1 (7 for DIGITS=2)
- PW (localparam), 2·BW (14 for DIGITS=2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted when busy=0
- op  in  2  0=sum, 1=sub, 2=mult, 3=div
- a  in  4·DIGITS  operand A, packed BCD, most-significant digit in the top nibble
- b  in  4·DIGITS  operand B, packed BCD
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; results valid from this cycle on
- result_lo  out  4·DIGITS  low BCD digits (sum, difference magnitude, product low, quotient)
- result_hi  out  4·DIGITS  high BCD digits (carry digit, 0, product high, remainder)
- neg  out  1  sub only: a<b
- err  out  1  divide-by-zero or non-BCD digit in a or b

## Operation
- States: IDLE → LOAD → EXEC → CONV → DONE → IDLE.
- IDLE/DONE with start=1: latch op, a and b; go to LOAD. Input changes after the accept edge are ignored.
- LOAD (1 cycle):
  - Convert a and b to binary.
  - Flag err if any nibble >9, or if op=div and b=0.
- EXEC: sum, sub and mult take 1 cycle; div takes BW cycles (restoring, one quotient bit per cycle).
  - sum: a+b.
  - sub: |a−b|; neg=1 only if a<b. When a=b, neg=0.
  - mult: full product, at most 10^(2·DIGITS)−1.
  - div: quotient and remainder.
- CONV: always PW cycles, one double-dabble shift per cycle. For div, quotient and remainder are converted concurrently.
- DONE (1 cycle): result_lo, result_hi, neg and err are registered together; done=1, busy=0.
- Result mapping:
  - sum: result_hi = 0 or 1 (carry digit).
  - sub: result_hi = 0.
  - mult: {result_hi, result_lo} = product.
  - div: result_lo = quotient, result_hi = remainder.
- err=1 forces result_lo=0, result_hi=0 and neg=0. Latency is unchanged.
- Outputs hold their values until the next DONE or reset.
- start while busy=1 is ignored; it is not queued.

## Timing
- Reset values: state IDLE, busy=0, done=0, result_lo=0, result_hi=0, neg=0, err=0.
- Accept edge = rising clk edge with start=1 and busy=0. busy rises in the following cycle.
- done is high for exactly one cycle, E+PW+1 cycles after the accept edge, where E=1 (sum/sub/mult) or BW (div).
  - DIGITS=2: 16 cycles for sum/sub/mult, 22 cycles for div.
- Back-to-back: start=1 during the DONE cycle is accepted. busy is then high in the next cycle, with no idle gap.
- rst asserted at any point, including mid-EXEC or mid-CONV:
  - Outputs go to reset values immediately.
  - The operation is discarded and no done pulse is produced.
  - The first start after rst is released is processed normally.

## Test plan
(DIGITS=2)
- sum a=0x57, b=0x68 → done at cycle 16; result_hi=0x01, result_lo=0x25, neg=0, err=0. Also a=0x99, b=0x99 → 0x01 / 0x98.
- sub a=0x23, b=0x58 → result_lo=0x35, neg=1, result_hi=0x00. Also a=b=0x42 → result_lo=0x00, neg=0.
- mult a=0x99, b=0x99 → result_hi=0x98, result_lo=0x01. Also a=0x00, b=0x75 → both 0x00. done at cycle 16.
- div a=0x97, b=0x07 → done at cycle 22; result_lo=0x13, result_hi=0x06. Also b=0x00 → err=1, both results 0x00, done still at cycle 22.
- a=0x1A (sum) → err=1, results 0x00, done at cycle 16.
- Handshake and reset:
  - Pulse start at cycle 5 of a running mult → ignored; original result only.
  - start held high through the DONE cycle → second op accepted, busy stays high with no gap.
  - rst at cycle 8 of a div → all outputs 0, no done pulse; the next sum completes correctly.
